prio_encode_stream: RTL
=======================

# prio_encode_stream

Serializing 8:3 priority encoder: the reverse path of the 3:8 one-hot decoder. It accepts an 8-bit request vector under a valid/ready handshake and emits the 3-bit index of every set bit, one per accepted output beat, lowest index first. Index k maps to bit k, the same mapping the decoder uses, so a decoder driven by `out_code` reproduces each set bit in turn. It sits between request-collecting logic and any consumer that processes one indexed event at a time.

## Interface
- N, 8, request vector width; fixed at 8 for this release.
- CW, 3, code width, equal to $clog2(N).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  `in_vec` is offered.
- in_ready  out  1  block can accept a vector.
- in_vec  in  8  request vector; any number of bits may be set.
- out_valid  out  1  `out_code` is valid.
- out_ready  in  1  consumer takes the current code.
- out_code  out  3  index of the lowest remaining set bit.
- out_last  out  1  current code is the final one for this vector.
- zero_drop  out  1  one-cycle pulse: an all-zero vector was accepted and discarded.

## Operation
- State machine with two states, IDLE and EMIT. There is an internal 8-bit register `pend`.
- Reset: state=IDLE, pend=0. Outputs under reset: in_ready=0, out_valid=0, out_code=0, out_last=0, zero_drop=0.
- in_ready = (state==IDLE) && rst_n.
- IDLE, on in_valid&&in_ready:
  - If in_vec!=0: pend<=in_vec, go to EMIT.
  - If in_vec==0: stay in IDLE and assert zero_drop for the next cycle.
- EMIT:
  - out_valid=1.
  - out_code = index of the lowest set bit of pend.
  - out_last = (pend has exactly one bit set).
- EMIT, on out_valid&&out_ready: clear the bit at out_code in pend. If out_last, return to IDLE.
- While out_valid&&!out_ready, out_code and out_last hold stable.
- In IDLE: out_valid=0, out_code=0, out_last=0.
- Priority order is LSB first. Duplicate codes are never produced. The number of codes emitted equals popcount(in_vec).
- No new vector is accepted until the last code of the current vector has been taken. There is no overlap.
- Reset mid-operation: pend is discarded, state returns to IDLE, and no further codes are emitted.

## Timing
- Input handshake at edge t: out_valid is first high in cycle t+1.
- Throughput: one code per cycle while out_ready=1. A vector with p set bits occupies p cycles in EMIT.
- The last handshake at edge u gives in_ready=1 in cycle u+1. The minimum period between accepted vectors is p+1 cycles.
- zero_drop is high exactly in cycle t+1 after an all-zero acceptance. in_ready stays 1 throughout.
- All outputs come from registered state. There is no combinational path from any input to any output except rst_n to in_ready.

## Structure
- Package `prio_enc_pkg` holds N, CW, and the state typedef (IDLE, EMIT).
- Sub-module `lsb_prio_find`: combinational. Input is the 8-bit vector; outputs are the 3-bit index of the lowest set bit and a `single` flag (popcount==1). It is instantiated once, on pend.

## Test plan
- After reset, in_vec=8'b0000_0001 with out_ready=1: one beat, out_code=0, out_last=1. in_ready returns to 1 in the following cycle.
- in_vec=8'b1010_0110 with out_ready=1: codes 1,2,5,7 on four consecutive cycles. out_last is high only on code 7.
- in_vec=8'hFF with out_ready toggling 1,0,0,1,...: codes 0 through 7, each held stable while stalled. in_ready stays 0 until the last handshake.
- in_vec=8'h00 accepted: zero_drop pulses for one cycle, out_valid stays 0, and the next vector 8'h80 yields code 7 with out_last=1.
- Apply 8'hF0, take code 4, then drop rst_n for one cycle: out_valid=0 the next cycle. After release, in_ready=1 and codes 5..7 never appear.
- Loopback: `out_code` drives a 3:8 decoder, and the OR of its outputs over all beats equals the original in_vec. Check with 100 random nonzero vectors.

Source files
------------

// File: rtl/prio_encode_stream_pkg.sv
// rtl/prio_encode_stream_pkg.sv - shared widths and state type for the serializing priority encoder
package prio_enc_pkg;
  localparam int N  = 8;
  localparam int CW = $clog2(N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;
endpackage

// File: rtl/prio_encode_stream_if.sv
// rtl/prio_encode_stream_if.sv - request-in / code-out handshake bundle
interface prio_encode_stream_if;
  import prio_enc_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_code;
  logic          out_last;
  logic          zero_drop;

  // Encoder side
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_code, out_last, zero_drop
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_code, out_last, zero_drop
  );
endinterface

// File: rtl/prio_encode_stream_lsb_prio_find.sv
// rtl/prio_encode_stream_lsb_prio_find.sv - lowest-set-bit index and single-bit flag
module lsb_prio_find
  import prio_enc_pkg::*;
(
  input  logic [N-1:0]  vec,
  output logic [CW-1:0] idx,
  output logic          single
);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = CW'(i);
    end
  end

  // Exactly one bit set: nonzero and clearing the lowest bit leaves nothing
  always_comb begin
    single = (vec != '0) && ((vec & (vec - N'(1))) == '0);
  end

endmodule

// File: rtl/prio_encode_stream.sv
// rtl/prio_encode_stream.sv - serializing 8:3 priority encoder, LSB first
module prio_encode_stream
  import prio_enc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  prio_encode_stream_if.slave  bus
);

  localparam logic [N-1:0] ONE = N'(1);

  state_t        state_q, state_d;
  logic [N-1:0]  pend_q, pend_d;
  logic          zero_drop_q, zero_drop_d;
  logic [CW-1:0] lsb_idx;
  logic          lsb_single;

  lsb_prio_find u_find (
    .vec    (pend_q),
    .idx    (lsb_idx),
    .single (lsb_single)
  );

  // Outputs decode registered state only; rst_n gating on in_ready is the one exception
  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_code  = (state_q == EMIT) ? lsb_idx : '0;
  assign bus.out_last  = (state_q == EMIT) && lsb_single;
  assign bus.zero_drop = zero_drop_q;

  // Next-state: load a nonzero vector, drop an empty one, peel one bit per taken beat
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    zero_drop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_vec != '0) begin
            pend_d  = bus.in_vec;
            state_d = EMIT;
          end else begin
            zero_drop_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          pend_d = pend_q & ~(ONE << lsb_idx);
          if (lsb_single) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  // State registers; reset discards any pending bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      zero_drop_q <= zero_drop_d;
    end
  end

endmodule
